// File: rtl/freq_meter_pkg.sv
// Shared constants for the frequency meter: default gate window, counter widths
// and the saturation ceiling of the default result width.
package freq_meter_pkg;
    localparam int GATE_CYCLES_DEF = 50_000_000;
    localparam int WIN_W_DEF       = 26;
    localparam int RES_W_DEF       = 16;
    localparam int RES_MAX         = (2 ** RES_W_DEF) - 1;
endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus a delay flop; emits a one-cycle rise pulse for each
// rising edge of an asynchronous input. Usable for buttons and other async inputs.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);
    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;
endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over a fixed gate window of clk cycles and
// publishes the saturated count with a one-cycle valid pulse per window.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int WIN_W       = WIN_W_DEF,
    parameter int RES_W       = RES_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic [RES_W-1:0] freq,
    output logic             freq_valid,
    output logic             overflow
);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(GATE_CYCLES - 1);
    localparam logic [RES_W-1:0] CNT_MAX  = {RES_W{1'b1}};

    logic rise;

    logic [WIN_W-1:0] win_q, win_d;
    logic [RES_W-1:0] edge_q, edge_d;
    logic             sat_q, sat_d;
    logic [RES_W-1:0] freq_q, freq_d;
    logic             ovf_q, ovf_d;
    logic             vld_q, vld_d;
    logic [RES_W:0]   sum;

    sync_edge_det u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(sig_in),
        .rise    (rise)
    );

    // A rise landing on the closing cycle is folded into the closing result.
    assign sum = {1'b0, edge_q} + (RES_W + 1)'(rise);

    always_comb begin
        win_d  = win_q;
        edge_d = edge_q;
        sat_d  = sat_q;
        freq_d = freq_q;
        ovf_d  = ovf_q;
        vld_d  = 1'b0;
        if (!enable) begin
            win_d  = '0;
            edge_d = '0;
            sat_d  = 1'b0;
        end else if (win_q == WIN_LAST) begin
            win_d  = '0;
            edge_d = '0;
            sat_d  = 1'b0;
            freq_d = sum[RES_W] ? CNT_MAX : sum[RES_W-1:0];
            ovf_d  = sat_q | sum[RES_W];
            vld_d  = 1'b1;
        end else begin
            win_d = win_q + WIN_W'(1);
            if (rise) begin
                if (edge_q == CNT_MAX) sat_d  = 1'b1;
                else                   edge_d = edge_q + RES_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_q  <= '0;
            edge_q <= '0;
            sat_q  <= 1'b0;
            freq_q <= '0;
            ovf_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            win_q  <= win_d;
            edge_q <= edge_d;
            sat_q  <= sat_d;
            freq_q <= freq_d;
            ovf_q  <= ovf_d;
            vld_q  <= vld_d;
        end
    end

    assign freq       = freq_q;
    assign freq_valid = vld_q;
    assign overflow   = ovf_q;
endmodule
